// File: rtl/alu_pkg.sv
// Shared opcode map, unit-enable bit positions, issue FSM encoding and the
// payload record carried from the issue stage to the ALU groups.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_ADDC = 4'd2;
  localparam logic [3:0] OP_SUBC = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_ANDN = 4'd7;
  localparam logic [3:0] OP_ROTL = 4'd8;
  localparam logic [3:0] OP_ROTR = 4'd9;

  localparam int UE_ARITH = 0;
  localparam int UE_LOGIC = 1;
  localparam int UE_ROTL  = 2;
  localparam int UE_ROTR  = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SLEEP = 2'd1,
    ST_WAKE  = 2'd2
  } issue_state_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [3:0]  ue;
  } issue_payload_t;

  // Opcodes 10-15 are reserved and select no unit.
  function automatic logic [3:0] unit_decode(input logic [3:0] op);
    logic [3:0] ue;
    ue = '0;
    if (op[3:2] == 2'b00)   ue[UE_ARITH] = 1'b1;
    else if (op[3:2] == 2'b01) ue[UE_LOGIC] = 1'b1;
    else if (op == OP_ROTL) ue[UE_ROTL] = 1'b1;
    else if (op == OP_ROTR) ue[UE_ROTR] = 1'b1;
    return ue;
  endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Payload holding register for the issue stage. With ALU_ISSUE_SKID_EN defined
// a second entry absorbs one item while the output is stalled.
module alu_issue_skid
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_fire,
  input  issue_payload_t in_data,
  output logic           space,
  output logic           held,
  output logic           out_valid,
  input  logic           out_ready,
  output issue_payload_t out_data
);

  logic           ov;
  issue_payload_t od;

`ifdef ALU_ISSUE_SKID_EN
  logic           sv;
  issue_payload_t sd;

  // space depends only on flops, so no path from out_ready reaches in_ready.
  assign space = !sv;
  assign held  = sv;

  always_ff @(posedge clk) begin
    if (rst) begin
      ov <= 1'b0;
      od <= '0;
      sv <= 1'b0;
      sd <= '0;
    end else if (!ov || out_ready) begin
      if (sv) begin
        od <= sd;
        ov <= 1'b1;
        sv <= 1'b0;
      end else if (in_fire) begin
        od <= in_data;
        ov <= 1'b1;
      end else begin
        ov    <= 1'b0;
        od.ue <= '0;
      end
    end else if (in_fire) begin
      sd <= in_data;
      sv <= 1'b1;
    end
  end
`else
  assign space = !ov || out_ready;
  assign held  = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ov <= 1'b0;
      od <= '0;
    end else if (in_fire) begin
      od <= in_data;
      ov <= 1'b1;
    end else if (out_ready) begin
      ov    <= 1'b0;
      od.ue <= '0;
    end
  end
`endif

  assign out_valid = ov;
  assign out_data  = od;

endmodule

// File: rtl/alu_issue_stage.sv
// Operand issue stage in front of the ALU groups: registers operands, issues a
// one-hot unit enable and sleeps the ALU clock gate when idle (ALU_ISSUE_SKID_EN
// selects the two-entry skid variant of the payload register).
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int IDLE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  in_a,
  input  logic [15:0]  in_b,
  input  logic [3:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  out_a,
  output logic [15:0]  out_b,
  output logic [3:0]   out_amt,
  output logic [3:0]   out_op,
  output logic [3:0]   unit_en,
  output logic         gate_en,
  output issue_state_t dbg_state
);

  localparam int CW   = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam int LAST = (IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST);

  issue_state_t   state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           space, held, in_fire, idle;
  issue_payload_t in_pl, out_pl;

  // Handshake: an item moves on any rising edge where valid && ready are both
  // high; valid never waits on ready, and the output payload holds while
  // out_valid && !out_ready.
  assign in_ready = (state == ST_RUN) && space;
  assign in_fire  = in_valid && in_ready;
  assign in_pl    = '{a: in_a, b: in_b, op: in_op, ue: unit_decode(in_op)};

  alu_issue_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_fire   (in_fire),
    .in_data   (in_pl),
    .space     (space),
    .held      (held),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  assign idle = !in_valid && !out_valid && !held;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ST_RUN: begin
        if (IDLE_CYCLES == 0 || !idle) begin
          cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_SLEEP;
          cnt_n   = '0;
        end else if (cnt != '1) begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_SLEEP: begin
        if (in_valid) state_n = ST_WAKE;
      end
      // One settle cycle for the gated clock; the idle count restarts from zero.
      ST_WAKE: begin
        state_n = ST_RUN;
        cnt_n   = '0;
      end
      default: begin
        state_n = ST_RUN;
        cnt_n   = '0;
      end
    endcase
  end

  assign gate_en   = (state != ST_SLEEP);
  assign out_a     = out_pl.a;
  assign out_b     = out_pl.b;
  assign out_amt   = out_pl.b[3:0];
  assign out_op    = out_pl.op;
  assign unit_en   = out_pl.ue;
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, stall,
// sleep/wake and reset sequences, then random traffic against a queue model.
`timescale 1ns/1ps
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int IDLE = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, gate_en;
  logic [15:0]  in_a, in_b, out_a, out_b;
  logic [3:0]   in_op, out_op, out_amt, unit_en;
  issue_state_t dbg_state;

  int n_chk  = 0;
  int n_fail = 0;
  logic [35:0] exp_q[$];

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  ue;
    logic [3:0]  amt;
  } vec_t;
  vec_t vec[8];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  alu_issue_stage #(.IDLE_CYCLES(IDLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_amt   (out_amt),
    .out_op    (out_op),
    .unit_en   (unit_en),
    .gate_en   (gate_en),
    .dbg_state (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 4'd0, 16'd0, 16'd0);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Reference decode written from the opcode ranges.
  function automatic logic [3:0] exp_ue(input logic [3:0] op);
    int o;
    o = int'(op);
    if (o <= 3) return 4'b0001;
    if (o <= 7) return 4'b0010;
    if (o == 8) return 4'b0100;
    if (o == 9) return 4'b1000;
    return 4'b0000;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic sb_check();
    logic [35:0] e;
    if (!out_valid) return;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 1, 0);
      return;
    end
    e = exp_q[0];
    chk("sb_payload", {out_a, out_b, out_op}, e);
    chk("sb_amt", out_amt, e[7:4]);
    chk("sb_unit_en", unit_en, exp_ue(e[3:0]));
    if (out_ready) void'(exp_q.pop_front());
  endtask

  task automatic check_vec(input int j);
    chk("vec_valid", out_valid, 1);
    chk("vec_a", out_a, vec[j].a);
    chk("vec_b", out_b, vec[j].b);
    chk("vec_op", out_op, vec[j].op);
    chk("vec_amt", out_amt, vec[j].amt);
    chk("vec_unit_en", unit_en, vec[j].ue);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic        b_taken;
    logic        prev_stall;
    logic [35:0] prev_pl;
    int          idle_left;

    vec[0] = '{op: 4'd8,  a: 16'h8001, b: 16'h0001, ue: 4'b0100, amt: 4'h1};
    vec[1] = '{op: 4'd0,  a: 16'h1234, b: 16'h00FF, ue: 4'b0001, amt: 4'hF};
    vec[2] = '{op: 4'd3,  a: 16'hFFFF, b: 16'h0010, ue: 4'b0001, amt: 4'h0};
    vec[3] = '{op: 4'd4,  a: 16'hA5A5, b: 16'h5A5A, ue: 4'b0010, amt: 4'hA};
    vec[4] = '{op: 4'd7,  a: 16'h0000, b: 16'hFFFE, ue: 4'b0010, amt: 4'hE};
    vec[5] = '{op: 4'd9,  a: 16'h8000, b: 16'h000F, ue: 4'b1000, amt: 4'hF};
    vec[6] = '{op: 4'd12, a: 16'h1111, b: 16'h2227, ue: 4'b0000, amt: 4'h7};
    vec[7] = '{op: 4'd15, a: 16'hDEAD, b: 16'hBEEF, ue: 4'b0000, amt: 4'hF};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_payload", {out_a, out_b, out_amt, out_op, unit_en}, 0);
    chk("rst_gate_en", gate_en, 1);
    chk("rst_state", dbg_state, ST_RUN);

    // Vector table, streamed back-to-back with out_ready=1
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(1'b1, vec[0].op, vec[0].a, vec[0].b);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("vec_in_ready", in_ready, 1);
      if (i == 0) chk("vec_first_latency", out_valid, 0);
      else check_vec(i - 1);
      @(posedge clk); #1;
      if (i < 7) drive(1'b1, vec[i+1].op, vec[i+1].a, vec[i+1].b);
      else in_valid = 1'b0;
    end
    @(negedge clk);
    check_vec(7);
    @(posedge clk);
    @(negedge clk);
    chk("vec_drained", {out_valid, unit_en}, 0);

    // Output stall with two items
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 4'd9, 16'hCAFE, 16'h0003);
    @(negedge clk);
    chk("stall_accept_a", in_ready, 1);
    @(posedge clk); #1;
    drive(1'b1, 4'd5, 16'h0F0F, 16'h1234);
    b_taken = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_payload", {out_a, out_b, out_op, unit_en}, {16'hCAFE, 16'h0003, 4'd9, 4'b1000});
`ifdef ALU_ISSUE_SKID_EN
      chk("stall_skid_ready", in_ready, (k == 0));
`else
      chk("stall_ready_low", in_ready, 0);
`endif
      if (in_valid && in_ready) b_taken = 1'b1;
      @(posedge clk); #1;
      if (b_taken) in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("retire_a", {out_valid, out_a}, {1'b1, 16'hCAFE});
    if (in_valid && in_ready) b_taken = 1'b1;
    chk("b_taken", b_taken, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("retire_b", {out_valid, out_a, out_b, out_op, unit_en},
        {1'b1, 16'h0F0F, 16'h1234, 4'd5, 4'b0010});
    @(posedge clk);
    @(negedge clk);
    chk("after_b", {out_valid, unit_en}, 0);

    // Sleep after IDLE idle cycles, then wake
    do_reset();
    for (int k = 1; k <= IDLE; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("idle_gate", gate_en, (k < IDLE));
    end
    chk("sleep_in_ready", in_ready, 0);
    drive(1'b1, 4'd8, 16'h0003, 16'h0002);
    @(posedge clk);
    @(negedge clk);
    chk("wake_state", dbg_state, ST_WAKE);
    chk("wake_gate", gate_en, 1);
    chk("wake_in_ready", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("wake_run", dbg_state, ST_RUN);
    chk("wake_accept_ready", in_ready, 1);
    chk("wake_no_out_yet", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("wake_out", {out_valid, out_a, unit_en}, {1'b1, 16'h0003, 4'b0100});

    // in_valid drops during WAKE: back to RUN with the idle count restarted
    do_reset();
    repeat (IDLE) @(posedge clk);
    @(negedge clk);
    chk("pulse_sleep", gate_en, 0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pulse_wake", dbg_state, ST_WAKE);
    for (int k = 1; k <= IDLE + 1; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("pulse_regate", gate_en, (k <= IDLE));
    end

    // Reset while the output is stalled
    do_reset();
    drive(1'b1, 4'd4, 16'hBEEF, 16'h0042);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_pre", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_payload", {out_a, out_b, out_amt, out_op, unit_en}, 0);
    chk("rst_mid_gate", gate_en, 1);

    // Random traffic against the queue model
    do_reset();
    exp_q.delete();
    idle_left  = 0;
    prev_stall = 1'b0;
    prev_pl    = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (idle_left > 0) begin
        idle_left--;
        in_valid = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        idle_left = $urandom_range(4, 10);
        in_valid  = 1'b0;
      end else begin
        drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
              16'($urandom), 16'($urandom));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prev_stall) chk("rand_stable", {out_a, out_b, out_op}, prev_pl);
      if (!gate_en) chk("rand_sleep_quiet", {out_valid, in_ready}, 0);
      sb_check();
      if (in_valid && in_ready) exp_q.push_back({in_a, in_b, in_op});
      prev_stall = out_valid && !out_ready;
      prev_pl    = {out_a, out_b, out_op};
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      sb_check();
      @(posedge clk); #1;
    end
    chk("rand_drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
